// File: rtl/sbox_word_serializer.sv
// sbox_word_serializer: byte-serial SubBytes/InvSubBytes over one shared composite-field S-box.
// The tower is GF(((2^2)^2)^2); basis-change matrices are derived at elaboration from the field polynomials.
module sbox_word_serializer #(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] in_word,
    input  logic                   in_dec,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] out_word,
    output logic                   busy
);
    localparam int IW = $clog2(NUM_BYTES);

    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        return {a[1] & b[1] ^ a[1] & b[0] ^ a[0] & b[1], a[1] & b[1] ^ a[0] & b[0]};
    endfunction

    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [1:0] hh;
        hh = gf4_mul(a[3:2], b[3:2]);
        return {hh ^ gf4_mul(a[3:2], b[1:0]) ^ gf4_mul(a[1:0], b[3:2]),
                gf4_mul(hh, 2'b10) ^ gf4_mul(a[1:0], b[1:0])};
    endfunction

    // In GF(4) the inverse of a nonzero element is its square, and 0 maps to 0.
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [1:0] di;
        di = gf4_sq(gf4_mul(gf4_sq(a[3:2]), 2'b10) ^ gf4_mul(a[3:2], a[1:0]) ^ gf4_sq(a[1:0]));
        return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
    endfunction

    function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b, input logic [3:0] lam);
        logic [3:0] hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_mul(hh, lam) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    function automatic logic [7:0] gf256_inv(input logic [7:0] a, input logic [3:0] lam);
        logic [3:0] di;
        di = gf16_inv(gf16_mul(gf16_mul(a[7:4], a[7:4]), lam) ^ gf16_mul(a[7:4], a[3:0])
                      ^ gf16_mul(a[3:0], a[3:0]));
        return {gf16_mul(a[7:4], di), gf16_mul(a[7:4] ^ a[3:0], di)};
    endfunction

    // Smallest lambda with no solution to t^2+t=lambda, making z^2+z+lambda irreducible.
    function automatic logic [3:0] find_lambda();
        logic [3:0] lam;
        logic       hit;
        lam = '0;
        for (int l = 1; l < 16; l++) begin
            hit = 1'b0;
            for (int t = 0; t < 16; t++)
                if ((gf16_mul(4'(t), 4'(t)) ^ 4'(t)) == 4'(l)) hit = 1'b1;
            if (!hit && lam == 4'd0) lam = 4'(l);
        end
        return lam;
    endfunction

    function automatic logic [7:0] apply(input logic [63:0] m, input logic [7:0] a);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (a[i]) r ^= m[8*i +: 8];
        return r;
    endfunction

    // Column i is beta^i, with beta a tower root of the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [63:0] tower_basis(input logic [3:0] lam);
        logic [7:0]  beta, c2, c4, c8, pw;
        logic [63:0] m;
        beta = '0;
        for (int c = 1; c < 256; c++) begin
            c2 = gf256_mul(8'(c), 8'(c), lam);
            c4 = gf256_mul(c2, c2, lam);
            c8 = gf256_mul(c4, c4, lam);
            if ((c8 ^ c4 ^ gf256_mul(c2, 8'(c), lam) ^ 8'(c) ^ 8'd1) == 8'd0 && beta == 8'd0)
                beta = 8'(c);
        end
        pw = 8'd1;
        m  = '0;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = pw;
            pw = gf256_mul(pw, beta, lam);
        end
        return m;
    endfunction

    function automatic logic [63:0] aes_basis(input logic [63:0] fwd);
        logic [63:0] m;
        m = '0;
        for (int j = 0; j < 8; j++)
            for (int a = 0; a < 256; a++)
                if (apply(fwd, 8'(a)) == 8'(1 << j)) m[8*j +: 8] = 8'(a);
        return m;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    localparam logic [3:0]  LAM    = find_lambda();
    localparam logic [63:0] TO_T   = tower_basis(LAM);
    localparam logic [63:0] FROM_T = aes_basis(TO_T);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_nx;
    logic [IW-1:0]          idx;
    logic [8*NUM_BYTES-1:0] src, res;
    logic                   mode;
    logic [7:0]             sb_in, sb_x, sb_y, sb_out;

    // Decryption undoes the affine step first, encryption applies it after the inversion.
    always_comb begin
        sb_in  = src[{idx, 3'b000} +: 8];
        sb_x   = mode ? rotl(sb_in, 1) ^ rotl(sb_in, 3) ^ rotl(sb_in, 6) ^ 8'h05 : sb_in;
        sb_y   = apply(FROM_T, gf256_inv(apply(TO_T, sb_x), LAM));
        sb_out = mode ? sb_y
                      : sb_y ^ rotl(sb_y, 1) ^ rotl(sb_y, 2) ^ rotl(sb_y, 3) ^ rotl(sb_y, 4) ^ 8'h63;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        busy      = state != IDLE;
        if (state == IDLE && in_valid) state_nx = BUSY;
        if (state == BUSY && idx == IW'(NUM_BYTES - 1)) state_nx = DONE;
        if (state == DONE && out_ready) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            src   <= '0;
            res   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_nx;
            if (in_ready && in_valid) begin
                src  <= in_word;
                mode <= in_dec;
                idx  <= '0;
            end
            if (state == BUSY) begin
                res[{idx, 3'b000} +: 8] <= sb_out;
                idx <= idx + 1'b1;
            end
        end
    end

    assign out_word = res;
endmodule
